// File: rtl/payload_pkg.sv
// Shared beat field map for the order payload (both directions)
// plus the inbound parser state encoding.
package payload_pkg;

    localparam int DATA_W = 256;
    localparam int BEATS  = 3;
    localparam int CNT_DW = 16;

    // beat0 (header) fields: LSB offset and width
    localparam int SEQ_LSB     = 224;
    localparam int SEQ_W       = 32;
    localparam int EPOCH_LSB   = 192;
    localparam int EPOCH_W     = 32;
    localparam int MS_LSB      = 176;
    localparam int MS_W        = 16;
    localparam int SESS_LSB    = 160;
    localparam int SESS_W      = 16;
    localparam int CMID_LSB    = 144;
    localparam int CMID_W      = 16;
    localparam int EXEC_LSB    = 136;
    localparam int EXEC_W      = 8;
    localparam int ACNO_LSB    = 104;
    localparam int ACNO_W      = 32;
    localparam int IFLAG_LSB   = 96;
    localparam int IFLAG_W     = 8;
    localparam int SIDE_LSB    = 88;
    localparam int SIDE_W      = 8;
    localparam int OTYPE_LSB   = 80;
    localparam int OTYPE_W     = 8;
    localparam int TIF_LSB     = 72;
    localparam int TIF_W       = 8;
    localparam int PRICE_LSB   = 40;
    localparam int PRICE_W     = 32;
    localparam int QTY_LSB     = 24;
    localparam int QTY_W       = 16;

    // beat1 (order) fields
    localparam int ORDNO_LSB   = 216;
    localparam int ORDNO_W     = 40;
    localparam int ORDID_LSB   = 184;
    localparam int ORDID_W     = 32;
    localparam int UDEF_LSB    = 120;
    localparam int UDEF_W      = 64;
    localparam int SYMTYPE_LSB = 112;
    localparam int SYMTYPE_W   = 8;

    // beat2 (symbol) field
    localparam int SYM_LSB     = 96;
    localparam int SYM_W       = 160;

    typedef enum logic [2:0] {
        B0,
        B1,
        B2,
        HOLD,
        DROP
    } pstate_e;

    function automatic logic [SEQ_W-1:0] hdr_seq(
        input logic [DATA_W-1:0] hdr
    );
        return hdr[SEQ_LSB +: SEQ_W];
    endfunction

endpackage

// File: rtl/payload_seq_check.sv
// Tracks the next expected MsgSeqNum and flags a
// mismatch against the header of the message in flight.
module payload_seq_check
    import payload_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             check,
    input  logic [SEQ_W-1:0] seq,
    output logic             gap
);

    logic [SEQ_W-1:0] expected_seq;

    assign gap = (seq != expected_seq);

    // resync to whatever arrived so one gap is flagged only once
    always_ff @(posedge clk) begin
        if (!resetn) begin
            expected_seq <= SEQ_W'(1);
        end else if (check) begin
            expected_seq <= seq + SEQ_W'(1);
        end
    end

endmodule

// File: rtl/payload_parser.sv
// Inbound execution-report parser: collects 3-beat messages,
// checks framing and sequence, holds one decoded report.
module payload_parser
    import payload_pkg::*;
#(
    parameter int CNT_W = CNT_DW
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [DATA_W-1:0] rpt_hdr,
    output logic [DATA_W-1:0] rpt_ord,
    output logic [SYM_W-1:0]  rpt_sym,
    output logic              rpt_seq_gap,
    output logic              frame_err,
    output logic [CNT_W-1:0]  msg_count,
    output logic [CNT_W-1:0]  err_count
);

    pstate_e state_q;
    pstate_e state_d;

    logic accept;
    logic take_hdr;
    logic take_ord;
    logic take_sym;
    logic err_d;
    logic done_ok;
    logic gap;

    assign s_tready  = resetn & ((state_q != HOLD) | rpt_ready);
    assign rpt_valid = (state_q == HOLD);
    assign accept    = s_tvalid & s_tready;

    always_comb begin
        state_d  = state_q;
        take_hdr = 1'b0;
        take_ord = 1'b0;
        take_sym = 1'b0;
        err_d    = 1'b0;
        done_ok  = 1'b0;
        unique case (state_q)
            B0, HOLD: begin
                if (state_q == HOLD && rpt_ready) begin
                    state_d = B0;
                end
                // in HOLD an accepted beat implies release
                if (accept) begin
                    if (s_tlast) begin
                        err_d   = 1'b1;
                        state_d = B0;
                    end else begin
                        take_hdr = 1'b1;
                        state_d  = B1;
                    end
                end
            end
            B1: begin
                if (accept) begin
                    if (s_tlast) begin
                        err_d   = 1'b1;
                        state_d = B0;
                    end else begin
                        take_ord = 1'b1;
                        state_d  = B2;
                    end
                end
            end
            B2: begin
                if (accept) begin
                    if (s_tlast) begin
                        take_sym = 1'b1;
                        done_ok  = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = DROP;
                    end
                end
            end
            DROP: begin
                if (accept && s_tlast) begin
                    state_d = B0;
                end
            end
            default: begin
                state_d = B0;
            end
        endcase
    end

    payload_seq_check u_seq (
        .clk    (clk),
        .resetn (resetn),
        .check  (done_ok),
        .seq    (hdr_seq(rpt_hdr)),
        .gap    (gap)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= B0;
            rpt_hdr     <= '0;
            rpt_ord     <= '0;
            rpt_sym     <= '0;
            rpt_seq_gap <= 1'b0;
            frame_err   <= 1'b0;
            msg_count   <= '0;
            err_count   <= '0;
        end else begin
            state_q   <= state_d;
            frame_err <= err_d;
            if (take_hdr) begin
                rpt_hdr <= s_tdata;
            end
            if (take_ord) begin
                rpt_ord <= s_tdata;
            end
            if (take_sym) begin
                rpt_sym <= s_tdata[SYM_LSB +: SYM_W];
            end
            if (done_ok) begin
                rpt_seq_gap <= gap;
            end
            if (err_d && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (rpt_valid && rpt_ready) begin
                msg_count <= msg_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_payload_parser.sv
// Self-checking bench for payload_parser: directed scenarios
// plus a randomized stream against a packet-level model.
module tb_payload_parser;

    localparam int CNT_W = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [255:0] s_tdata = '0;
    logic         s_tvalid = 1'b0;
    logic         s_tlast = 1'b0;
    logic         s_tready;
    logic         rpt_valid;
    logic         rpt_ready = 1'b0;
    logic [255:0] rpt_hdr;
    logic [255:0] rpt_ord;
    logic [159:0] rpt_sym;
    logic         rpt_seq_gap;
    logic         frame_err;
    logic [CNT_W-1:0] msg_count;
    logic [CNT_W-1:0] err_count;

    typedef struct {
        logic [255:0] hdr;
        logic [255:0] ord;
        logic [159:0] sym;
        logic         gap;
    } rpt_t;

    rpt_t got_q[$];
    int   fe_pulses = 0;
    int   checks = 0;
    int   errors = 0;

    payload_parser #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .rpt_valid  (rpt_valid),
        .rpt_ready  (rpt_ready),
        .rpt_hdr    (rpt_hdr),
        .rpt_ord    (rpt_ord),
        .rpt_sym    (rpt_sym),
        .rpt_seq_gap(rpt_seq_gap),
        .frame_err  (frame_err),
        .msg_count  (msg_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    // passive monitor: record every delivered report and error pulse
    always @(negedge clk) begin
        if (resetn && rpt_valid && rpt_ready) begin
            got_q.push_back('{rpt_hdr, rpt_ord, rpt_sym, rpt_seq_gap});
        end
        if (frame_err) fe_pulses++;
    end

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] mk_hdr(input logic [31:0] seq);
        logic [255:0] v;
        v = rnd256();
        v[255:224] = seq;
        return v;
    endfunction

    task automatic do_reset();
        resetn = 1'b0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
    endtask

    task automatic send_beat(input logic [255:0] d, input bit last, input int idle);
        int n;
        s_tvalid = 1'b0;
        repeat (idle) begin @(posedge clk); #1; end
        s_tdata = d;
        s_tlast = last;
        s_tvalid = 1'b1;
        for (n = 0; n < 500; n++) begin
            @(negedge clk);
            if (s_tready) break;
        end
        checks++;
        if (n == 500) begin
            errors++;
            $display("FAIL tready_timeout: s_tready=%0b after %0d cycles, required 1", s_tready, n);
        end
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
    endtask

    task automatic send_msg(input logic [255:0] h, input logic [255:0] o, input logic [255:0] s, input int idle);
        send_beat(h, 1'b0, idle);
        send_beat(o, 1'b0, idle);
        send_beat(s, 1'b1, idle);
    endtask

    task automatic wait_reports(input int target);
        int n;
        for (n = 0; n < 2000; n++) begin
            if (got_q.size() >= target) break;
            @(posedge clk); #1;
        end
        checks++;
        if (got_q.size() < target) begin
            errors++;
            $display("FAIL report_timeout: got %0d reports, required %0d", got_q.size(), target);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (s_tready !== 1'b0 || rpt_valid !== 1'b0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: tready=%b valid=%b ferr=%b, required 0 0 0", s_tready, rpt_valid, frame_err);
        end
        checks++;
        if (rpt_hdr !== '0 || rpt_ord !== '0 || rpt_sym !== '0 || rpt_seq_gap !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: hdr=%h sym=%h gap=%b, required zero", rpt_hdr, rpt_sym, rpt_seq_gap);
        end
        checks++;
        if (msg_count !== '0 || err_count !== '0) begin
            errors++;
            $display("FAIL reset_cnt: msg=%0d err=%0d, required 0 0", msg_count, err_count);
        end
        resetn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: s_tready=%b, required 1", s_tready);
        end
    endtask

    task automatic test_single();
        logic [255:0] h, o, s;
        do_reset();
        rpt_ready = 1'b1;
        h = mk_hdr(32'd1);
        h[71:40] = 32'd10000;
        h[39:24] = 16'd2;
        h[95:88] = 8'd1;
        o = rnd256();
        s = rnd256();
        s[255:96] = 160'd1025;
        send_beat(h, 1'b0, 0);
        send_beat(o, 1'b0, 0);
        checks++;
        if (rpt_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: rpt_valid=%b, required 0", rpt_valid);
        end
        send_beat(s, 1'b1, 0);
        checks++;
        if (rpt_valid !== 1'b1 || rpt_seq_gap !== 1'b0) begin
            errors++;
            $display("FAIL single_valid: valid=%b gap=%b, required 1 0", rpt_valid, rpt_seq_gap);
        end
        checks++;
        if (rpt_hdr[71:40] !== 32'd10000 || rpt_hdr[39:24] !== 16'd2 || rpt_hdr[95:88] !== 8'd1) begin
            errors++;
            $display("FAIL single_fields: price=%0d qty=%0d side=%0d, required 10000 2 1",
                     rpt_hdr[71:40], rpt_hdr[39:24], rpt_hdr[95:88]);
        end
        checks++;
        if (rpt_hdr !== h || rpt_ord !== o || rpt_sym !== 160'd1025) begin
            errors++;
            $display("FAIL single_raw: sym=%0d, required 1025 (hdr/ord compared raw)", rpt_sym);
        end
        @(posedge clk); #1;
        checks++;
        if (rpt_valid !== 1'b0 || msg_count !== 16'd1) begin
            errors++;
            $display("FAIL single_after: valid=%b msg_count=%0d, required 0 1", rpt_valid, msg_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [255:0] h1, o1, s1, h2, o2, s2;
        int base;
        do_reset();
        rpt_ready = 1'b0;
        base = got_q.size();
        h1 = mk_hdr(32'd1); o1 = rnd256(); s1 = rnd256();
        h2 = mk_hdr(32'd2); o2 = rnd256(); s2 = rnd256();
        send_msg(h1, o1, s1, 0);
        checks++;
        if (rpt_valid !== 1'b1 || s_tready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_hold: valid=%b tready=%b, required 1 0", rpt_valid, s_tready);
        end
        fork
            send_msg(h2, o2, s2, 0);
            begin
                repeat (5) @(posedge clk);
                #1;
                checks++;
                if (s_tready !== 1'b0 || rpt_hdr !== h1 || rpt_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_stable: tready=%b valid=%b hdr_seq=%0d, required 0 1 1",
                             s_tready, rpt_valid, rpt_hdr[255:224]);
                end
                rpt_ready = 1'b1;
                @(posedge clk); #1;
                checks++;
                if (rpt_valid !== 1'b0 || rpt_hdr !== h2) begin
                    errors++;
                    $display("FAIL b2b_release: valid=%b hdr_seq=%0d, required 0 2", rpt_valid, rpt_hdr[255:224]);
                end
            end
        join
        wait_reports(base + 2);
        if (got_q.size() >= base + 2) begin
            checks++;
            if (got_q[base].hdr !== h1 || got_q[base].ord !== o1 || got_q[base].sym !== s1[255:96]) begin
                errors++;
                $display("FAIL b2b_msg1: seq=%0d, required 1 with intact payload", got_q[base].hdr[255:224]);
            end
            checks++;
            if (got_q[base+1].hdr !== h2 || got_q[base+1].ord !== o2 || got_q[base+1].sym !== s2[255:96]
                || got_q[base+1].gap !== 1'b0) begin
                errors++;
                $display("FAIL b2b_msg2: seq=%0d gap=%b, required 2 0", got_q[base+1].hdr[255:224], got_q[base+1].gap);
            end
        end
    endtask

    task automatic test_seq_gap();
        logic [31:0] seqs[5];
        logic [31:0] nxt;
        logic [255:0] h;
        logic         exp_gap;
        int base;
        seqs = '{32'd1, 32'd3, 32'd4, 32'hFFFF_FFFF, 32'd0};
        do_reset();
        rpt_ready = 1'b1;
        base = got_q.size();
        for (int i = 0; i < 5; i++) begin
            h = mk_hdr(seqs[i]);
            send_msg(h, rnd256(), rnd256(), $urandom_range(0, 2));
        end
        wait_reports(base + 5);
        nxt = 32'd1;
        for (int i = 0; i < 5 && base + i < got_q.size(); i++) begin
            exp_gap = (seqs[i] != nxt);
            nxt = seqs[i] + 32'd1;
            checks++;
            if (got_q[base+i].gap !== exp_gap || got_q[base+i].hdr[255:224] !== seqs[i]) begin
                errors++;
                $display("FAIL seq_gap[%0d]: seq=%h gap=%b, required seq=%h gap=%b",
                         i, got_q[base+i].hdr[255:224], got_q[base+i].gap, seqs[i], exp_gap);
            end
        end
    endtask

    task automatic test_frame_early();
        logic [255:0] h;
        int base, fe0;
        do_reset();
        rpt_ready = 1'b1;
        base = got_q.size();
        fe0 = fe_pulses;
        send_beat(mk_hdr(32'd1), 1'b0, 0);
        send_beat(rnd256(), 1'b1, 0);
        checks++;
        if (frame_err !== 1'b1 || err_count !== 16'd1) begin
            errors++;
            $display("FAIL early_err: frame_err=%b err_count=%0d, required 1 1", frame_err, err_count);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_err !== 1'b0 || rpt_valid !== 1'b0) begin
            errors++;
            $display("FAIL early_pulse: frame_err=%b valid=%b, required 0 0", frame_err, rpt_valid);
        end
        h = mk_hdr(32'd1);
        send_msg(h, rnd256(), rnd256(), 0);
        wait_reports(base + 1);
        checks++;
        if (got_q.size() != base + 1 || got_q[base].hdr !== h || got_q[base].gap !== 1'b0) begin
            errors++;
            $display("FAIL early_recover: reports=%0d, required %0d clean gap-free", got_q.size() - base, 1);
        end
        checks++;
        if (fe_pulses - fe0 != 1) begin
            errors++;
            $display("FAIL early_pulses: %0d pulses, required 1", fe_pulses - fe0);
        end
    endtask

    task automatic test_drop();
        logic [255:0] h;
        int base;
        do_reset();
        rpt_ready = 1'b1;
        base = got_q.size();
        send_beat(mk_hdr(32'd1), 1'b0, 0);
        send_beat(rnd256(), 1'b0, 0);
        send_beat(rnd256(), 1'b0, 0);
        checks++;
        if (frame_err !== 1'b1 || rpt_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_err: frame_err=%b valid=%b, required 1 0", frame_err, rpt_valid);
        end
        send_beat(mk_hdr(32'd1), 1'b0, 0);
        send_beat(rnd256(), 1'b1, 0);
        h = mk_hdr(32'd1);
        send_msg(h, rnd256(), rnd256(), 0);
        wait_reports(base + 1);
        checks++;
        if (got_q.size() != base + 1 || got_q[base].hdr !== h || err_count !== 16'd1) begin
            errors++;
            $display("FAIL drop_recover: reports=%0d err_count=%0d, required 1 1", got_q.size() - base, err_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [255:0] h;
        int base, fe0;
        do_reset();
        rpt_ready = 1'b1;
        base = got_q.size();
        fe0 = fe_pulses;
        send_beat(mk_hdr(32'd7), 1'b0, 0);
        send_beat(rnd256(), 1'b0, 0);
        resetn = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (rpt_hdr !== '0 || rpt_ord !== '0 || rpt_valid !== 1'b0 || frame_err !== 1'b0
            || err_count !== '0 || msg_count !== '0) begin
            errors++;
            $display("FAIL mid_reset: hdr_seq=%0d valid=%b ferr=%b err=%0d, required all zero",
                     rpt_hdr[255:224], rpt_valid, frame_err, err_count);
        end
        resetn = 1'b1;
        h = mk_hdr(32'd1);
        send_msg(h, rnd256(), rnd256(), 0);
        wait_reports(base + 1);
        checks++;
        if (got_q.size() != base + 1 || got_q[base].hdr !== h || got_q[base].gap !== 1'b0
            || fe_pulses != fe0) begin
            errors++;
            $display("FAIL mid_recover: reports=%0d pulses=%0d, required 1 0", got_q.size() - base, fe_pulses - fe0);
        end
    endtask

    task automatic test_random();
        logic [256:0] beats[$];
        rpt_t         exp_q[$];
        logic [31:0]  nxt, seq;
        logic [255:0] d, h, o, s;
        int base, fe0, exp_err, len, kind;
        bit drv_done;
        do_reset();
        base = got_q.size();
        fe0 = fe_pulses;
        exp_err = 0;
        nxt = 32'd1;
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(0, 9);
            len = (kind == 0) ? 1 : (kind == 1) ? 2 : (kind == 2) ? 4 : (kind == 3) ? 5 : 3;
            seq = ($urandom_range(0, 4) == 0) ? $urandom : nxt;
            h = mk_hdr(seq); o = rnd256(); s = rnd256();
            for (int b = 0; b < len; b++) begin
                d = (b == 0) ? h : (b == 1) ? o : (b == 2) ? s : rnd256();
                beats.push_back({(b == len - 1), d});
            end
            if (len == 3) begin
                exp_q.push_back('{h, o, s[255:96], (seq != nxt)});
                nxt = seq + 32'd1;
            end else begin
                exp_err++;
            end
        end
        drv_done = 1'b0;
        fork
            begin
                foreach (beats[i]) send_beat(beats[i][255:0], beats[i][256], $urandom_range(0, 2));
                drv_done = 1'b1;
            end
            while (!drv_done) begin
                @(posedge clk); #1;
                rpt_ready = ($urandom_range(0, 3) != 0);
            end
        join
        rpt_ready = 1'b1;
        wait_reports(base + exp_q.size());
        @(posedge clk); #1;
        foreach (exp_q[i]) begin
            if (base + i < got_q.size()) begin
                checks++;
                if (got_q[base+i].hdr !== exp_q[i].hdr || got_q[base+i].ord !== exp_q[i].ord
                    || got_q[base+i].sym !== exp_q[i].sym || got_q[base+i].gap !== exp_q[i].gap) begin
                    errors++;
                    $display("FAIL rand_rpt[%0d]: seq=%h gap=%b, required seq=%h gap=%b", i,
                             got_q[base+i].hdr[255:224], got_q[base+i].gap, exp_q[i].hdr[255:224], exp_q[i].gap);
                end
            end
        end
        checks++;
        if (got_q.size() - base != exp_q.size() || msg_count != CNT_W'(exp_q.size())) begin
            errors++;
            $display("FAIL rand_count: reports=%0d msg_count=%0d, required %0d",
                     got_q.size() - base, msg_count, exp_q.size());
        end
        checks++;
        if (err_count != CNT_W'(exp_err) || fe_pulses - fe0 != exp_err) begin
            errors++;
            $display("FAIL rand_err: err_count=%0d pulses=%0d, required %0d",
                     err_count, fe_pulses - fe0, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_seq_gap();
        test_frame_early();
        test_drop();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
